// File: rtl/pipe_hold_ctrl_pkg.sv
// Shared types and constants for the pipeline hold/flush sequencer.
//   state_e      : sequencer state encoding (idle, pending redirect, flushing)
//   FlushCycMax  : largest supported number of extra flush cycles
//   FlushCntW    : width of the flush-cycle down-counter
package pipe_hold_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPend  = 2'd1,
    StFlush = 2'd2
  } state_e;

  localparam int unsigned FlushCycMax = 3;
  localparam int unsigned FlushCntW   = 2;

  // Remaining flush cycles to load after a redirect, clamped to the supported range.
  function automatic logic [FlushCntW-1:0] flush_init(input int unsigned cyc);
    int unsigned c;
    c = (cyc > FlushCycMax) ? FlushCycMax : cyc;
    return c[FlushCntW-1:0];
  endfunction

endpackage

// File: rtl/gen_en_dff.sv
// Generic enable flop with asynchronous active-low reset to zero.
//   clk   : clock
//   rst_n : asynchronous reset, active-low
//   en    : load d into q on the next rising edge
//   d     : data in
//   q     : registered data out
module gen_en_dff #(
  parameter int unsigned DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  logic [DW-1:0] q_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= '0;
    end else if (en) begin
      q_q <= d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/pipe_hold_ctrl.sv
// Central pipeline hold/flush sequencer.
// Merges hold requests (EX multi-cycle, interrupt CSR update, fetch bus) with redirect
// requests (EX branch/jump, interrupt entry/mret) and drives the PC / IF-ID / ID-EX
// hold enables plus the PC load port. Redirects blocked by the bus are parked until the
// bus releases; a configurable number of flush cycles follows every redirect.
//   clk, rst_n                    : clock, asynchronous active-low reset
//   ex_jump_i / ex_jump_addr_i    : EX redirect request and target
//   int_jump_i / int_addr_i       : interrupt/mret redirect request and target
//   ex_hold_i, int_hold_i         : EX busy, interrupt controller hold
//   bus_hold_i                    : fetch bus not granted / waiting
//   cnt_clr_i                     : synchronous clear of the stall counter
//   pc_hold_o                     : freeze PC
//   if_flush_o, id_flush_o        : load bubble into IF/ID, ID/EX
//   pc_load_o, pc_load_addr_o     : load PC with the redirect target this cycle
//   stall_cnt_o                   : saturating count of cycles with pc_hold_o=1
module pipe_hold_ctrl
  import pipe_hold_ctrl_pkg::*;
#(
  parameter int unsigned AW        = 32,
  parameter int unsigned FLUSH_CYC = 1,
  parameter int unsigned CW        = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ex_jump_i,
  input  logic [AW-1:0] ex_jump_addr_i,
  input  logic          int_jump_i,
  input  logic [AW-1:0] int_addr_i,
  input  logic          ex_hold_i,
  input  logic          int_hold_i,
  input  logic          bus_hold_i,
  input  logic          cnt_clr_i,
  output logic          pc_hold_o,
  output logic          if_flush_o,
  output logic          id_flush_o,
  output logic          pc_load_o,
  output logic [AW-1:0] pc_load_addr_o,
  output logic [CW-1:0] stall_cnt_o
);

  localparam logic [FlushCntW-1:0] FlushInit = flush_init(FLUSH_CYC);

  state_e                 state_q, state_d;
  logic [FlushCntW-1:0]   flush_q, flush_d;
  logic [CW-1:0]          stall_cnt_q;
  logic [AW-1:0]          pend_addr;
  logic                   pend_en;

  logic                   jump;
  logic [AW-1:0]          target;
  logic                   redir_req;
  logic                   hold_c, ifl_c, idl_c, load_c;
  logic [AW-1:0]          addr_c;

  // Interrupt redirect wins over EX redirect.
  assign jump   = int_jump_i | ex_jump_i;
  assign target = int_jump_i ? int_addr_i : ex_jump_addr_i;

  // While flushing only bubbles are in flight, so a stale EX jump must not redirect.
  assign redir_req = (state_q == StFlush) ? int_jump_i : jump;

  always_comb begin
    state_d = state_q;
    flush_d = flush_q;
    pend_en = 1'b0;
    hold_c  = 1'b0;
    ifl_c   = 1'b0;
    idl_c   = 1'b0;
    load_c  = 1'b0;
    addr_c  = '0;

    unique case (state_q)
      StPend: begin
        ifl_c = 1'b1;
        idl_c = 1'b1;
        if (bus_hold_i) begin
          hold_c  = 1'b1;
          // A newer interrupt target replaces the parked one.
          pend_en = int_jump_i;
        end else begin
          load_c = 1'b1;
          addr_c = int_jump_i ? int_addr_i : pend_addr;
          if (FLUSH_CYC == 0) begin
            state_d = StIdle;
            flush_d = '0;
          end else begin
            state_d = StFlush;
            flush_d = FlushInit;
          end
        end
      end

      StIdle, StFlush: begin
        if (redir_req) begin
          ifl_c = 1'b1;
          idl_c = 1'b1;
          if (bus_hold_i) begin
            hold_c  = 1'b1;
            pend_en = 1'b1;
            state_d = StPend;
            flush_d = '0;
          end else begin
            load_c = 1'b1;
            addr_c = target;
            if (FLUSH_CYC == 0) begin
              state_d = StIdle;
              flush_d = '0;
            end else begin
              state_d = StFlush;
              flush_d = FlushInit;
            end
          end
        end else if (state_q == StFlush) begin
          ifl_c = 1'b1;
          idl_c = 1'b1;
          if (bus_hold_i) begin
            hold_c = 1'b1;
          end else begin
            flush_d = flush_q - 1'b1;
            if (flush_q <= 1) begin
              state_d = StIdle;
              flush_d = '0;
            end
          end
        end else if (ex_hold_i || int_hold_i) begin
          hold_c = 1'b1;
          ifl_c  = 1'b1;
          idl_c  = 1'b1;
        end else if (bus_hold_i) begin
          // ID/EX may keep advancing; only the fetch side is frozen.
          hold_c = 1'b1;
          ifl_c  = 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
        flush_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
    end
  end

  // Parked redirect target; d is always the selected target since only an interrupt
  // can overwrite it once parked.
  gen_en_dff #(
    .DW (AW)
  ) u_pend_addr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (pend_en),
    .d     (target),
    .q     (pend_addr)
  );

  // Outputs are forced quiet during reset even though they are combinational.
  assign pc_hold_o      = rst_n & hold_c;
  assign if_flush_o     = rst_n & ifl_c;
  assign id_flush_o     = rst_n & idl_c;
  assign pc_load_o      = rst_n & load_c;
  assign pc_load_addr_o = rst_n ? addr_c : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if (pc_hold_o && (stall_cnt_q != {CW{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hold_ctrl.sv
// Scoreboard bench for pipe_hold_ctrl. Three instances share stimulus:
//   inst0: FLUSH_CYC=1, CW=32   inst1: FLUSH_CYC=3, CW=4   inst2: FLUSH_CYC=0, CW=4
module tb_pipe_hold_ctrl;

  typedef struct packed {
    logic        hold;
    logic        ifl;
    logic        idl;
    logic        load;
    logic [31:0] addr;
    logic [31:0] cnt;
  } obs_t;

  typedef struct packed {
    obs_t o0;
    obs_t o1;
    obs_t o2;
  } obs3_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_jump = 1'b0, int_jump = 1'b0;
  logic [31:0] ex_addr = '0, int_addr = '0;
  logic        ex_hold = 1'b0, int_hold = 1'b0, bus_hold = 1'b0, cnt_clr = 1'b0;

  logic        hold0, ifl0, idl0, load0, hold1, ifl1, idl1, load1, hold2, ifl2, idl2, load2;
  logic [31:0] addr0, addr1, addr2, cnt0;
  logic [3:0]  cnt1, cnt2;

  always #5 clk = ~clk;

  pipe_hold_ctrl #(.AW(32), .FLUSH_CYC(1), .CW(32)) dut0 (
    .clk(clk), .rst_n(rst_n), .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_addr),
    .int_jump_i(int_jump), .int_addr_i(int_addr), .ex_hold_i(ex_hold), .int_hold_i(int_hold),
    .bus_hold_i(bus_hold), .cnt_clr_i(cnt_clr), .pc_hold_o(hold0), .if_flush_o(ifl0),
    .id_flush_o(idl0), .pc_load_o(load0), .pc_load_addr_o(addr0), .stall_cnt_o(cnt0)
  );
  pipe_hold_ctrl #(.AW(32), .FLUSH_CYC(3), .CW(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_addr),
    .int_jump_i(int_jump), .int_addr_i(int_addr), .ex_hold_i(ex_hold), .int_hold_i(int_hold),
    .bus_hold_i(bus_hold), .cnt_clr_i(cnt_clr), .pc_hold_o(hold1), .if_flush_o(ifl1),
    .id_flush_o(idl1), .pc_load_o(load1), .pc_load_addr_o(addr1), .stall_cnt_o(cnt1)
  );
  pipe_hold_ctrl #(.AW(32), .FLUSH_CYC(0), .CW(4)) dut2 (
    .clk(clk), .rst_n(rst_n), .ex_jump_i(ex_jump), .ex_jump_addr_i(ex_addr),
    .int_jump_i(int_jump), .int_addr_i(int_addr), .ex_hold_i(ex_hold), .int_hold_i(int_hold),
    .bus_hold_i(bus_hold), .cnt_clr_i(cnt_clr), .pc_hold_o(hold2), .if_flush_o(ifl2),
    .id_flush_o(idl2), .pc_load_o(load2), .pc_load_addr_o(addr2), .stall_cnt_o(cnt2)
  );

  // Reference model: a parked-redirect flag, a count of flush cycles still owed, the
  // parked target and the stall count.
  int              fcyc[3] = '{1, 3, 0};
  longint unsigned cmax[3] = '{64'hFFFF_FFFF, 64'd15, 64'd15};
  bit              m_parked[3];
  int              m_left[3];
  logic [31:0]     m_paddr[3];
  longint unsigned m_cnt[3];

  obs3_t exp_q[$];
  int    total = 0;
  int    bad = 0;
  int    cyc = 0;

  task automatic model_step(input int k, output obs_t e);
    logic        any_jump, redirect;
    logic [31:0] tgt;
    bit          flushing;
    e = '0;
    if (!rst_n) begin
      m_parked[k] = 0;
      m_left[k]   = 0;
      m_paddr[k]  = '0;
      m_cnt[k]    = 0;
      return;
    end
    e.cnt    = m_cnt[k][31:0];
    any_jump = ex_jump | int_jump;
    tgt      = int_jump ? int_addr : ex_addr;
    flushing = m_left[k] > 0;
    if (m_parked[k]) begin
      e.ifl = 1; e.idl = 1;
      if (bus_hold) begin
        e.hold = 1;
        if (int_jump) m_paddr[k] = int_addr;
      end else begin
        e.load = 1;
        e.addr = int_jump ? int_addr : m_paddr[k];
        m_parked[k] = 0;
        m_left[k]   = fcyc[k];
      end
    end else begin
      redirect = flushing ? int_jump : any_jump;
      if (redirect) begin
        e.ifl = 1; e.idl = 1;
        if (bus_hold) begin
          e.hold      = 1;
          m_parked[k] = 1;
          m_paddr[k]  = tgt;
          m_left[k]   = 0;
        end else begin
          e.load    = 1;
          e.addr    = tgt;
          m_left[k] = fcyc[k];
        end
      end else if (flushing) begin
        e.ifl = 1; e.idl = 1;
        if (bus_hold) e.hold = 1;
        else m_left[k] = m_left[k] - 1;
      end else if (ex_hold || int_hold) begin
        e.hold = 1; e.ifl = 1; e.idl = 1;
      end else if (bus_hold) begin
        e.hold = 1; e.ifl = 1;
      end
    end
    if (cnt_clr) m_cnt[k] = 0;
    else if (e.hold && m_cnt[k] < cmax[k]) m_cnt[k] = m_cnt[k] + 1;
  endtask

  task automatic cycle(input logic r, input logic ej, input logic [31:0] ea,
                       input logic ij, input logic [31:0] ia, input logic eh,
                       input logic ih, input logic bh, input logic clr);
    obs3_t x;
    @(posedge clk);
    #1;
    rst_n = r; ex_jump = ej; ex_addr = ea; int_jump = ij; int_addr = ia;
    ex_hold = eh; int_hold = ih; bus_hold = bh; cnt_clr = clr;
    model_step(0, x.o0);
    model_step(1, x.o1);
    model_step(2, x.o2);
    exp_q.push_back(x);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1, 0, '0, 0, '0, 0, 0, 0, 0);
  endtask

  function automatic void check(input int k, input obs_t a, input obs_t e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL inst%0d cycle %0d: got hold=%b if=%b id=%b load=%b addr=%h cnt=%0d, want hold=%b if=%b id=%b load=%b addr=%h cnt=%0d",
               k, cyc, a.hold, a.ifl, a.idl, a.load, a.addr, a.cnt,
               e.hold, e.ifl, e.idl, e.load, e.addr, e.cnt);
    end
  endfunction

  // Monitor: outputs are presented every cycle; compare mid-cycle against the queue.
  always @(negedge clk) begin
    obs3_t e;
    obs_t  a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{hold0, ifl0, idl0, load0, addr0, cnt0};
      check(0, a, e.o0);
      a = '{hold1, ifl1, idl1, load1, addr1, {28'd0, cnt1}};
      check(1, a, e.o1);
      a = '{hold2, ifl2, idl2, load2, addr2, {28'd0, cnt2}};
      check(2, a, e.o2);
      cyc++;
    end
  end

  initial begin
    // Reset, then single EX jump with free bus.
    cycle(0, 0, '0, 0, '0, 0, 0, 0, 0);
    cycle(0, 0, '0, 0, '0, 0, 0, 0, 0);
    idle(1);
    cycle(1, 1, 32'h100, 0, '0, 0, 0, 0, 0);
    idle(5);
    // Jump deferred by a 3-cycle bus stall.
    cycle(1, 1, 32'h200, 0, '0, 0, 0, 1, 0);
    cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    idle(5);
    // Parked target overwritten by interrupt; EX jump ignored while parked.
    cycle(1, 1, 32'h200, 0, '0, 0, 0, 1, 0);
    cycle(1, 1, 32'h300, 1, 32'h80, 0, 0, 1, 0);
    cycle(1, 1, 32'h400, 0, '0, 0, 0, 1, 0);
    idle(5);
    cycle(1, 1, 32'h300, 1, 32'h80, 0, 0, 0, 0);
    idle(5);
    // EX hold for 5 cycles, then bus hold alone, then interrupt hold.
    for (int i = 0; i < 5; i++) cycle(1, 0, '0, 0, '0, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) cycle(1, 0, '0, 0, '0, 0, 1, 0, 0);
    idle(2);
    // Bus stall in the middle of a flush; holds and EX jumps ignored while flushing.
    cycle(1, 1, 32'h500, 0, '0, 0, 0, 0, 0);
    cycle(1, 1, 32'h600, 0, '0, 1, 1, 0, 0);
    cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    idle(6);
    // Interrupt restarts a flush in progress.
    cycle(1, 1, 32'h700, 0, '0, 0, 0, 0, 0);
    cycle(1, 0, '0, 1, 32'h44, 0, 0, 0, 0);
    cycle(1, 0, '0, 1, 32'h48, 0, 0, 1, 0);
    idle(6);
    // Asynchronous reset while a redirect is parked.
    cycle(1, 1, 32'h900, 0, '0, 0, 0, 1, 0);
    cycle(1, 0, '0, 0, '0, 0, 0, 1, 0);
    cycle(0, 0, '0, 0, '0, 0, 0, 1, 0);
    cycle(0, 0, '0, 0, '0, 0, 0, 0, 0);
    idle(3);
    // Saturation of the 4-bit counters, then a clear that wins over a held cycle.
    for (int i = 0; i < 20; i++) cycle(1, 0, '0, 0, '0, 1, 0, 0, 0);
    cycle(1, 0, '0, 0, '0, 1, 0, 0, 1);
    idle(2);
    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 199) != 0), ($urandom_range(0, 3) == 0), $urandom(),
            ($urandom_range(0, 7) == 0), $urandom(), ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 49) == 0));
    end
    idle(1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_hold_ctrl.md
Name: pipe_hold_ctrl

Overview:
Central pipeline hold/flush sequencer for the core.
- Merges hold requests from the EX stage (multi-cycle op), the bus, and the interrupt controller with redirect requests from EX (branch/jump) and the interrupt controller (trap entry/mret).
- Drives the hold_en pins of the PC, IF/ID and ID/EX pipe registers, plus the PC load port.
- Sequences multi-cycle flushes and jumps deferred by bus stalls, and keeps a stall-cycle performance counter.

Parameters:
AW, 32, PC/jump address width
FLUSH_CYC, 1, extra flush cycles after the redirect cycle, legal range 0..3
CW, 32, stall counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous, active-low
ex_jump_i  in  1  EX branch/jump taken
ex_jump_addr_i  in  AW  EX redirect target
int_jump_i  in  1  interrupt/mret redirect
int_addr_i  in  AW  interrupt redirect target
ex_hold_i  in  1  EX multi-cycle busy (e.g. divider)
int_hold_i  in  1  interrupt controller CSR-update hold
bus_hold_i  in  1  fetch bus not granted / wait
cnt_clr_i  in  1  synchronous clear of stall counter
pc_hold_o  out  1  freeze PC
if_flush_o  out  1  hold_en of IF/ID pipe reg (loads bubble)
id_flush_o  out  1  hold_en of ID/EX pipe reg (loads bubble)
pc_load_o  out  1  load PC with pc_load_addr_o this cycle
pc_load_addr_o  out  AW  redirect target
stall_cnt_o  out  CW  cycles with pc_hold_o=1, saturating

Behaviour:
Reset and output timing:
- Async reset (rst_n low): state IDLE, flush_cnt=0, pend_addr=0, stall_cnt=0.
- All control outputs are forced 0 while rst_n is low. pc_load_addr_o=0.
- Control outputs are combinational from state+inputs (same-cycle response, zero latency). State, counters and pend_addr are registered.

Redirect select:
- jump = int_jump_i | ex_jump_i.
- target = int_jump_i ? int_addr_i : ex_jump_addr_i. Interrupt wins when both are asserted.

States IDLE, PEND, FLUSH.

IDLE:
- jump & !bus_hold_i: pc_load=1, pc_load_addr=target, if_flush=id_flush=1. Next state is FLUSH with flush_cnt=FLUSH_CYC, or IDLE if FLUSH_CYC=0.
- jump & bus_hold_i: pc_hold=if_flush=id_flush=1, pc_load=0. Latch pend_addr=target. Next state PEND.
- else ex_hold_i|int_hold_i: pc_hold=if_flush=id_flush=1.
- else bus_hold_i: pc_hold=if_flush=1, id_flush=0.
- else: all outputs 0.

PEND:
- bus_hold_i=1: pc_hold=if_flush=id_flush=1. int_jump_i overwrites pend_addr with int_addr_i. ex_jump_i is ignored, because ID/EX holds a bubble.
- bus_hold_i=0: pc_load=1, pc_load_addr = int_jump_i ? int_addr_i : pend_addr, if_flush=id_flush=1. Next state FLUSH/IDLE, with the same FLUSH_CYC rule as IDLE.

FLUSH:
- if_flush=id_flush=1.
- bus_hold_i=0: pc_hold=0 and flush_cnt decrements. When flush_cnt==1 on that cycle, next state IDLE.
- bus_hold_i=1: pc_hold=1 and flush_cnt is held.
- int_jump_i in FLUSH restarts the redirect exactly as in IDLE (pc_load or PEND) and reloads flush_cnt. ex_jump_i is ignored.
- ex_hold_i and int_hold_i are ignored in FLUSH, since bubbles only are in flight.

Stall counter:
- stall_cnt increments on every cycle with pc_hold_o=1 and saturates at all-ones.
- cnt_clr_i takes priority and sets it to 0 that cycle, without counting that cycle.

Invariants:
- pc_load_o and pc_hold_o are never 1 together.
- id_flush_o=1 implies if_flush_o=1.

Decomposition:
- Package pipe_hold_ctrl_pkg holds the state enum (IDLE=2'd0, PEND=2'd1, FLUSH=2'd2) and the FLUSH_CYC max constant (3).
- pend_addr is a gen_en_dff instance (en = latch condition).
- stall_cnt and flush_cnt are local always_ff blocks. No other sub-module.

Test Plan:
1. IDLE, ex_jump_i=1, ex_jump_addr_i=32'h100, bus_hold=0 -> same cycle pc_load=1, addr=0x100, if/id_flush=1. Next cycle (FLUSH_CYC=1): if/id_flush=1, pc_hold=0. Then all outputs 0.
2. ex_jump_i with addr 0x200 while bus_hold_i=1 for 3 cycles -> pc_hold=1 for those 3 cycles, no pc_load. First cycle with bus_hold=0: pc_load=1, addr=0x200. stall_cnt advanced by 3.
3. PEND with pend_addr=0x200, int_jump_i=1, int_addr_i=0x80 -> on bus release pc_load_addr=0x80. Simultaneous ex_jump(0x300)+int_jump(0x80) in IDLE -> addr=0x80.
4. ex_hold_i=1 for 5 cycles (bus idle) -> pc_hold/if_flush/id_flush=1 for those 5 cycles. bus_hold alone -> id_flush=0. stall_cnt+=5.
5. FLUSH_CYC=3 with bus_hold=1 mid-flush -> exactly 3 non-stalled flush cycles after the redirect, counter frozen during the stall. FLUSH_CYC=0 -> back to IDLE the cycle after the redirect.
6. rst_n dropped asynchronously in PEND -> outputs 0 immediately. After release: IDLE, stall_cnt=0, no pc_load. Saturation check with CW=4: 20 held cycles -> stall_cnt_o=4'hF.
